// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - Execute-stage ALU: ID/EX operand register, ALU evaluation, EX/MEM result register
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ValidD,
  input  logic [2:0]       ALUControlD,
  input  logic [WIDTH-1:0] SrcAD,
  input  logic [WIDTH-1:0] SrcBD,
  input  logic             StallE,
  input  logic             FlushE,
  output logic             ValidM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic             ZeroM,
  output logic             OverflowM,
  output logic             IllegalM
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             valid_e_q, valid_e_d;
  logic [2:0]       ctrl_e_q, ctrl_e_d;
  logic [WIDTH-1:0] src_a_e_q, src_a_e_d;
  logic [WIDTH-1:0] src_b_e_q, src_b_e_d;

  logic             valid_m_q, valid_m_d;
  logic [WIDTH-1:0] out_m_q, out_m_d;
  logic             zero_m_q, zero_m_d;
  logic             ovf_m_q, ovf_m_d;
  logic             ill_m_q, ill_m_d;

  logic [WIDTH-1:0] sum, diff, res;
  logic             lt_s, lt_u, eq, ovf, ill;

  // Flush outranks stall so a squashed op cannot linger in Execute.
  always_comb begin
    valid_e_d = valid_e_q;
    ctrl_e_d  = ctrl_e_q;
    src_a_e_d = src_a_e_q;
    src_b_e_d = src_b_e_q;
    if (FlushE) begin
      valid_e_d = 1'b0;
      ctrl_e_d  = 3'b000;
      src_a_e_d = '0;
      src_b_e_d = '0;
    end else if (!StallE) begin
      valid_e_d = ValidD;
      ctrl_e_d  = ALUControlD;
      src_a_e_d = SrcAD;
      src_b_e_d = SrcBD;
    end
  end

  // slt uses a real signed compare so it stays correct when a-b overflows.
  always_comb begin
    sum  = src_a_e_q + src_b_e_q;
    diff = src_a_e_q - src_b_e_q;
    lt_s = $signed(src_a_e_q) < $signed(src_b_e_q);
    lt_u = src_a_e_q < src_b_e_q;
    eq   = src_a_e_q == src_b_e_q;
    res  = '0;
    ovf  = 1'b0;
    ill  = 1'b0;
    case (ctrl_e_q)
      OP_ADD: begin
        res = sum;
        ovf = (src_a_e_q[WIDTH-1] == src_b_e_q[WIDTH-1]) && (sum[WIDTH-1] != src_a_e_q[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (src_a_e_q[WIDTH-1] != src_b_e_q[WIDTH-1]) && (diff[WIDTH-1] != src_a_e_q[WIDTH-1]);
      end
      OP_AND:  res = src_a_e_q & src_b_e_q;
      OP_OR:   res = src_a_e_q | src_b_e_q;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_CMP:  res = {{(WIDTH-3){1'b0}}, lt_u, lt_s, eq};
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    valid_m_d = 1'b0;
    out_m_d   = '0;
    zero_m_d  = 1'b0;
    ovf_m_d   = 1'b0;
    ill_m_d   = 1'b0;
    if (!StallE && valid_e_q) begin
      valid_m_d = 1'b1;
      out_m_d   = res;
      zero_m_d  = !ill && (res == '0);
      ovf_m_d   = ovf;
      ill_m_d   = ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e_q <= 1'b0;
      ctrl_e_q  <= 3'b000;
      src_a_e_q <= '0;
      src_b_e_q <= '0;
      valid_m_q <= 1'b0;
      out_m_q   <= '0;
      zero_m_q  <= 1'b0;
      ovf_m_q   <= 1'b0;
      ill_m_q   <= 1'b0;
    end else begin
      valid_e_q <= valid_e_d;
      ctrl_e_q  <= ctrl_e_d;
      src_a_e_q <= src_a_e_d;
      src_b_e_q <= src_b_e_d;
      valid_m_q <= valid_m_d;
      out_m_q   <= out_m_d;
      zero_m_q  <= zero_m_d;
      ovf_m_q   <= ovf_m_d;
      ill_m_q   <= ill_m_d;
    end
  end

  assign ValidM    = valid_m_q;
  assign ALUOutM   = out_m_q;
  assign ZeroM     = zero_m_q;
  assign OverflowM = ovf_m_q;
  assign IllegalM  = ill_m_q;

endmodule
